// File: rtl/march_pkg.sv
// -----------------------------------------------------------------------------
// march_pkg
// Shared definitions for the March C- memory test controller:
//   - controller state encoding (legacy numeric values, wrapped in an enum)
//   - March element index M0..M5
//   - per-element constants: sweep direction, read-expected background,
//     write background, and whether the element reads and/or writes
//   - next_elem(): element sequencing helper
// Background values are single bits; the controller replicates them across
// the data width (0 = all-zeros, 1 = all-ones).
// -----------------------------------------------------------------------------
package march_pkg;

  // Legacy state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_ONLY   = 3'd1;
  localparam logic [2:0] ST_RD        = 3'd2;
  localparam logic [2:0] ST_RD_CMP_WR = 3'd3;
  localparam logic [2:0] ST_RD_CMP    = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_WR_ONLY   = ST_WR_ONLY,
    S_RD        = ST_RD,
    S_RD_CMP_WR = ST_RD_CMP_WR,
    S_RD_CMP    = ST_RD_CMP,
    S_DONE      = ST_DONE
  } march_state_e;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } march_elem_e;

  typedef struct packed {
    logic up;      // 1 = sweep 0..N-1, 0 = sweep N-1..0
    logic has_rd;  // element starts each address with a read
    logic has_wr;  // element writes each address
    logic rd_val;  // expected read background
    logic wr_val;  // write background
  } elem_cfg_t;

  localparam elem_cfg_t CFG_M0   = '{up: 1'b1, has_rd: 1'b0, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
  localparam elem_cfg_t CFG_M1   = '{up: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
  localparam elem_cfg_t CFG_M2   = '{up: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
  localparam elem_cfg_t CFG_M3   = '{up: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
  localparam elem_cfg_t CFG_M4   = '{up: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
  localparam elem_cfg_t CFG_M5   = '{up: 1'b0, has_rd: 1'b1, has_wr: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
  localparam elem_cfg_t CFG_NONE = '{up: 1'b0, has_rd: 1'b0, has_wr: 1'b0, rd_val: 1'b0, wr_val: 1'b0};

  // Table indexed by march_elem_e; entries 6 and 7 are unreachable.
  localparam elem_cfg_t [7:0] ELEM_CFG = '{
    CFG_NONE, CFG_NONE, CFG_M5, CFG_M4, CFG_M3, CFG_M2, CFG_M1, CFG_M0
  };

  function automatic march_elem_e next_elem(input march_elem_e e);
    march_elem_e n;
    case (e)
      M0:      n = M1;
      M1:      n = M2;
      M2:      n = M3;
      M3:      n = M4;
      M4:      n = M5;
      default: n = M5;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/march_addr_cnt.sv
// -----------------------------------------------------------------------------
// march_addr_cnt
// Up/down address counter for the March controller.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset (address -> 0)
//   i_load       : load start address (has priority over i_en)
//   i_load_ones  : load value select: 1 = all-ones (down sweep), 0 = zero
//   i_en         : step the address one position in direction i_up
//   i_up         : current sweep direction (also selects the terminal value)
//   o_addr       : current address (registered)
//   o_term       : address is the last one of the current sweep
//                  (N-1 when sweeping up, 0 when sweeping down)
// -----------------------------------------------------------------------------
module march_addr_cnt #(
  parameter int AD_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_load_ones,
  input  logic            i_en,
  input  logic            i_up,
  output logic [AD_W-1:0] o_addr,
  output logic            o_term
);

  logic [AD_W-1:0] r_addr;

  // Address register: reload at element start, step inside an element.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= {AD_W{1'b0}};
    end else if (i_load) begin
      r_addr <= i_load_ones ? {AD_W{1'b1}} : {AD_W{1'b0}};
    end else if (i_en) begin
      r_addr <= i_up ? (r_addr + AD_W'(1'b1)) : (r_addr - AD_W'(1'b1));
    end else begin
      r_addr <= r_addr;
    end
  end

  // Element end is flagged explicitly so the controller never relies on wrap.
  always_comb begin
    if (i_up) begin
      o_term = (r_addr == {AD_W{1'b1}});
    end else begin
      o_term = (r_addr == {AD_W{1'b0}});
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/march_controller.sv
// -----------------------------------------------------------------------------
// march_controller
// March C- memory test sequencer:
//   M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0),
//   M5 down(r0).
// A run takes 11*N cycles from the first memory strobe; done pulses one
// cycle after the last M5 compare. Read data is expected the cycle after
// mem_re, so each read element uses a read cycle (RD) followed by a compare
// cycle (RD_CMP_WR, or RD_CMP in M5) at the same address.
// Ports:
//   clk, reset      : clock (rising edge), synchronous active-high reset
//   start           : single-cycle run request, accepted only in IDLE
//   mem_addr        : memory address
//   mem_we, mem_re  : write / read strobes (never both high)
//   mem_wdata       : write data
//   mem_rdata       : read data, valid the cycle after mem_re
//   busy            : high while the run is in progress (low during done)
//   done            : one-cycle end-of-run pulse
//   fail, fail_addr : sticky mismatch flag and first failing address,
//                     both cleared when a start is accepted
// Configuration macro:
//   MARCH_FAIL_STOP_EN : when defined, the first mismatch ends the run; the
//                        write of that compare cycle is suppressed and done
//                        pulses on the next cycle.
// -----------------------------------------------------------------------------
module march_controller
  import march_pkg::*;
#(
  parameter int AD_W = 4,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [AD_W-1:0] mem_addr,
  output logic            mem_we,
  output logic            mem_re,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [AD_W-1:0] fail_addr
);

  march_state_e    r_state;
  march_state_e    w_nxt_state;
  march_elem_e     r_elem;
  march_elem_e     w_nxt_elem;
  march_elem_e     w_adv_elem;

  logic            w_load;
  logic            w_load_ones;
  logic            w_en;
  logic            w_term;
  logic            w_start_acc;
  logic            w_cmp;
  logic            w_mismatch;
  logic            w_stop;
  logic            w_nxt_we;
  logic [AD_W-1:0] w_addr;

  logic            r_mem_we;
  logic            r_mem_re;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_busy;
  logic            r_done;
  logic            r_fail;
  logic [AD_W-1:0] r_fail_addr;

  march_addr_cnt #(
    .AD_W (AD_W)
  ) u_addr_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_load_ones (w_load_ones),
    .i_en        (w_en),
    .i_up        (ELEM_CFG[r_elem].up),
    .o_addr      (w_addr),
    .o_term      (w_term)
  );

  assign w_adv_elem = next_elem(r_elem);
  assign w_cmp      = (r_state == S_RD_CMP_WR) || (r_state == S_RD_CMP);
  assign w_mismatch = w_cmp && (mem_rdata != {DW{ELEM_CFG[r_elem].rd_val}});

`ifdef MARCH_FAIL_STOP_EN
  // The compare result is only known in the compare cycle itself, so the
  // already-registered write strobe is cancelled combinationally.
  assign w_stop = w_mismatch;
  assign mem_we = r_mem_we & ~w_stop;
`else
  assign w_stop = 1'b0;
  assign mem_we = r_mem_we;
`endif

  // Next-state, element sequencing and address counter control.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_elem  = r_elem;
    w_load      = 1'b0;
    w_load_ones = 1'b0;
    w_en        = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_nxt_elem  = M0;
          w_nxt_state = S_WR_ONLY;
          w_load      = 1'b1;
          w_load_ones = 1'b0;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_RD: begin
        w_nxt_state = ELEM_CFG[r_elem].has_wr ? S_RD_CMP_WR : S_RD_CMP;
      end
      // Last cycle spent on an address: step, or move to the next element
      // (reloading the address in this same cycle), or finish.
      S_WR_ONLY, S_RD_CMP_WR, S_RD_CMP: begin
        if (w_stop) begin
          w_nxt_state = S_DONE;
        end else if (!w_term) begin
          w_en        = 1'b1;
          w_nxt_state = ELEM_CFG[r_elem].has_rd ? S_RD : S_WR_ONLY;
        end else if (r_elem == M5) begin
          w_nxt_state = S_DONE;
        end else begin
          w_nxt_elem  = w_adv_elem;
          w_load      = 1'b1;
          w_load_ones = ~ELEM_CFG[w_adv_elem].up;
          w_nxt_state = ELEM_CFG[w_adv_elem].has_rd ? S_RD : S_WR_ONLY;
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_elem  = M0;
      end
    endcase
  end

  assign w_nxt_we = (w_nxt_state == S_WR_ONLY) || (w_nxt_state == S_RD_CMP_WR);

  // State, element and registered strobe/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_elem      <= M0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_wdata <= {DW{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_elem      <= w_nxt_elem;
      r_mem_we    <= w_nxt_we;
      r_mem_re    <= (w_nxt_state == S_RD);
      r_mem_wdata <= w_nxt_we ? {DW{ELEM_CFG[w_nxt_elem].wr_val}} : {DW{1'b0}};
      r_busy      <= (w_nxt_state != S_IDLE) && (w_nxt_state != S_DONE);
      r_done      <= (w_nxt_state == S_DONE);
    end
  end

  // Sticky fail flag; only the first mismatch of a run records its address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fail      <= 1'b0;
      r_fail_addr <= {AD_W{1'b0}};
    end else if (w_start_acc) begin
      r_fail      <= 1'b0;
      r_fail_addr <= {AD_W{1'b0}};
    end else if (w_mismatch && !r_fail) begin
      r_fail      <= 1'b1;
      r_fail_addr <= w_addr;
    end else begin
      r_fail      <= r_fail;
      r_fail_addr <= r_fail_addr;
    end
  end

  assign mem_addr  = w_addr;
  assign mem_re    = r_mem_re;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;

endmodule

// File: tb/tb_march_controller.sv
// -----------------------------------------------------------------------------
// tb_march_controller
// Self-checking bench for march_controller (AD_W=4, DW=8). A behavioural
// model walks March C- over a model memory (with an optional stuck-at cell)
// and produces the expected per-cycle strobe/address/status trace, which is
// compared against the DUT on every negative clock edge of the run.
// -----------------------------------------------------------------------------
module tb_march_controller;

  localparam int AD_W = 4;
  localparam int DW   = 8;
  localparam int N    = 16;
`ifdef MARCH_FAIL_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [AD_W-1:0] mem_addr;
  logic            mem_we;
  logic            mem_re;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            busy;
  logic            done;
  logic            fail;
  logic [AD_W-1:0] fail_addr;

  always #5 clk = ~clk;

  march_controller #(.AD_W(AD_W), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr)
  );

  // Memory with an optional stuck-at bit applied on read
  logic [DW-1:0] mem [N];
  bit flt_en   = 1'b0;
  int flt_addr = 0;
  int flt_bit  = 0;
  bit flt_val  = 1'b0;

  function automatic logic [DW-1:0] faulty_read(input int a, input logic [DW-1:0] d);
    logic [DW-1:0] m;
    m = d;
    if (flt_en && a == flt_addr) m[flt_bit] = flt_val;
    return m;
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= faulty_read(int'(mem_addr), mem[mem_addr]);
  end

  // Expected trace
  typedef struct {
    bit we;
    bit re;
    int addr;
    int wdata;
    bit f;
    int fa;
  } rec_t;

  rec_t tr[$];
  bit   fin_fail;
  int   fin_faddr;
  int   checks = 0;
  int   failures = 0;
  int   dut_addr [256];
  bit   dut_we   [256];

  function automatic rec_t mk(input bit we, input bit re, input int a, input int wd,
                              input bit f, input int fa);
    rec_t r;
    r.we = we; r.re = re; r.addr = a; r.wdata = wd; r.f = f; r.fa = fa;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // March C- walked element by element over a model memory.
  task automatic build_trace();
    logic [DW-1:0] m [N];
    logic [DW-1:0] rexp;
    logic [DW-1:0] wv;
    logic [DW-1:0] rd;
    bit up;
    bit hw;
    bit f;
    int fa;
    int a;
    tr.delete();
    f  = 1'b0;
    fa = 0;
    for (int k = 0; k < N; k++) begin
      tr.push_back(mk(1'b1, 1'b0, k, 0, f, fa));
      m[k] = '0;
    end
    for (int e = 1; e <= 5; e++) begin
      up   = (e <= 2);
      rexp = (e == 2 || e == 4) ? {DW{1'b1}} : {DW{1'b0}};
      wv   = (e == 1 || e == 3) ? {DW{1'b1}} : {DW{1'b0}};
      hw   = (e != 5);
      for (int k = 0; k < N; k++) begin
        a = up ? k : N - 1 - k;
        tr.push_back(mk(1'b0, 1'b1, a, 0, f, fa));
        rd = faulty_read(a, m[a]);
        if (rd != rexp && STOP) begin
          tr.push_back(mk(1'b0, 1'b0, a, 0, f, fa));
          fin_fail  = 1'b1;
          fin_faddr = a;
          return;
        end
        tr.push_back(mk(hw, 1'b0, a, int'(wv), f, fa));
        if (rd != rexp && !f) begin
          f  = 1'b1;
          fa = a;
        end
        if (hw) m[a] = wv;
      end
    end
    fin_fail  = f;
    fin_faddr = fa;
  endtask

  // pin: 0 none, 1 fault-free literal checks, 2 addr5/bit0 stuck-1 literal checks
  task automatic run_test(input string tag, input int extra_start, input int reset_at, input int pin);
    int busy_cnt;
    build_trace();
    busy_cnt = 0;
    @(negedge clk);
    chk($sformatf("%s.idle_busy", tag), busy, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < tr.size(); i++) begin
      chk($sformatf("%s.c%0d.we", tag, i), mem_we, tr[i].we);
      chk($sformatf("%s.c%0d.re", tag, i), mem_re, tr[i].re);
      chk($sformatf("%s.c%0d.addr", tag, i), mem_addr, tr[i].addr);
      if (tr[i].we) chk($sformatf("%s.c%0d.wdata", tag, i), mem_wdata, tr[i].wdata);
      chk($sformatf("%s.c%0d.busy", tag, i), busy, 1'b1);
      chk($sformatf("%s.c%0d.done", tag, i), done, 1'b0);
      chk($sformatf("%s.c%0d.fail", tag, i), fail, tr[i].f);
      chk($sformatf("%s.c%0d.faddr", tag, i), fail_addr, tr[i].fa);
      dut_addr[i] = int'(mem_addr);
      dut_we[i]   = mem_we;
      if (busy) busy_cnt++;
      if (i == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk($sformatf("%s.rst.we", tag), mem_we, 1'b0);
        chk($sformatf("%s.rst.re", tag), mem_re, 1'b0);
        chk($sformatf("%s.rst.busy", tag), busy, 1'b0);
        chk($sformatf("%s.rst.done", tag), done, 1'b0);
        chk($sformatf("%s.rst.fail", tag), fail, 1'b0);
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk($sformatf("%s.post_rst%0d.done", tag, j), done, 1'b0);
          chk($sformatf("%s.post_rst%0d.busy", tag, j), busy, 1'b0);
        end
        return;
      end
      start = (i == extra_start);
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("%s.end.done", tag), done, 1'b1);
    chk($sformatf("%s.end.busy", tag), busy, 1'b0);
    chk($sformatf("%s.end.we", tag), mem_we, 1'b0);
    chk($sformatf("%s.end.re", tag), mem_re, 1'b0);
    chk($sformatf("%s.end.fail", tag), fail, fin_fail);
    chk($sformatf("%s.end.faddr", tag), fail_addr, fin_faddr);
    @(negedge clk);
    chk($sformatf("%s.after.done", tag), done, 1'b0);
    chk($sformatf("%s.after.busy", tag), busy, 1'b0);
    if (pin == 1) begin
      chk($sformatf("%s.pin.len", tag), busy_cnt, 176);
      chk($sformatf("%s.pin.fail", tag), fail, 1'b0);
      chk($sformatf("%s.pin.m1a0", tag), dut_addr[16], 0);
      chk($sformatf("%s.pin.m1a1", tag), dut_addr[17], 0);
      chk($sformatf("%s.pin.m1a2", tag), dut_addr[18], 1);
      chk($sformatf("%s.pin.m1a3", tag), dut_addr[19], 1);
      chk($sformatf("%s.pin.m1last", tag), dut_addr[47], 15);
      chk($sformatf("%s.pin.m3a0", tag), dut_addr[80], 15);
      chk($sformatf("%s.pin.m3a1", tag), dut_addr[81], 15);
      chk($sformatf("%s.pin.m3a2", tag), dut_addr[82], 14);
      chk($sformatf("%s.pin.m3a3", tag), dut_addr[83], 14);
      chk($sformatf("%s.pin.m3last", tag), dut_addr[111], 0);
      for (int a = 0; a < N; a++)
        chk($sformatf("%s.pin.mem%0d", tag, a), mem[a], 8'h00);
    end else if (pin == 2) begin
      chk($sformatf("%s.pin.fail", tag), fail, 1'b1);
      chk($sformatf("%s.pin.faddr", tag), fail_addr, 5);
      chk($sformatf("%s.pin.len", tag), busy_cnt, STOP ? 28 : 176);
      chk($sformatf("%s.pin.cmp_we", tag), dut_we[27], STOP ? 1'b0 : 1'b1);
    end
  endtask

  initial begin
    int ex;
    int ra;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.addr", mem_addr, 0);
    chk("rst.we", mem_we, 1'b0);
    chk("rst.re", mem_re, 1'b0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.fail", fail, 1'b0);
    chk("rst.faddr", fail_addr, 0);
    reset = 1'b0;

    flt_en = 1'b0;
    run_test("clean", -1, -1, 1);

    flt_en = 1'b1; flt_addr = 5; flt_bit = 0; flt_val = 1'b1;
    run_test("sa1_a5", -1, -1, 2);

    // Extra start while busy after a detected fault: ignored, fail kept
    flt_en = 1'b1; flt_addr = 2; flt_bit = 3; flt_val = 1'b1;
    run_test("restart_busy", -1 + (STOP ? 11 : 121), -1, 0);

    // Reset in M2, then a full clean run
    flt_en = 1'b0;
    run_test("rst_m2", -1, 60, 0);
    run_test("clean_after_rst", 30, -1, 1);

    for (int t = 0; t < 8; t++) begin
      flt_en   = ($urandom_range(0, 1) == 1);
      flt_addr = $urandom_range(0, N - 1);
      flt_bit  = $urandom_range(0, DW - 1);
      flt_val  = ($urandom_range(0, 1) == 1);
      ex       = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 200) : -1;
      ra       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 170) : -1;
      run_test($sformatf("rnd%0d", t), ex, ra, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
